// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART memory loader: receiver and loader state
// encodings plus the two command bytes that select a target region.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Bit-level receiver states. R_PARITY is only entered when the design is
    // built with UART_RX_PARITY_EN defined.
    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_PARITY,
        R_STOP
    } rx_state_t;

    // Byte-level loader states.
    typedef enum logic [1:0] {
        L_IDLE,
        L_LEN,
        L_DATA,
        L_DONE
    } load_state_t;

    localparam logic [7:0] CMD_STR = 8'h53;  // 'S' : load string region
    localparam logic [7:0] CMD_PAT = 8'h50;  // 'P' : load pattern region

endpackage

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// Two-flop synchronizer plus bit-level UART receiver, LSB first, 8 data bits.
// Optional even parity bit between bit 7 and stop when UART_RX_PARITY_EN is
// defined; otherwise 8N1.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous serial line, idle high
//   rx_byte    out  last correctly framed byte
//   byte_valid out  1-cycle pulse, rx_byte updated
//   err        out  1-cycle pulse on bad stop bit (or parity mismatch)
// -----------------------------------------------------------------------------
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err
);
    import uart_pkg::*;

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    rx_state_t   state, state_next;
    logic [CW-1:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        rx_meta, rx_sync, rx_prev;
    logic        bit_tick, half_tick, parity_ok;

    assign bit_tick  = (cnt == CW'(CLKS_PER_BIT - 1));
    assign half_tick = (cnt == CW'(HALF - 1));
    assign parity_ok = ((^shreg) == rx_sync);

    // NOTE: every signal assigned in an always_comb gets a default first,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            R_IDLE:   if (rx_prev && !rx_sync) state_next = R_START;
            // Re-check the start bit at mid-bit; a high line means a glitch.
            R_START:  if (half_tick) state_next = rx_sync ? R_IDLE : R_DATA;
            R_DATA:   if (bit_tick && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                          state_next = R_PARITY;
`else
                          state_next = R_STOP;
`endif
                      end
            R_PARITY: if (bit_tick) state_next = parity_ok ? R_STOP : R_IDLE;
            R_STOP:   if (bit_tick) state_next = R_IDLE;
            default:  state_next = R_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= R_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            state      <= state_next;
            byte_valid <= 1'b0;
            err        <= 1'b0;

            // Counter restarts on every state change and every bit boundary,
            // so after the mid-start sample all later samples fall mid-bit.
            if (state == R_IDLE || state != state_next || bit_tick)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            if (state == R_START)
                bit_idx <= '0;

            if (state == R_DATA && bit_tick) begin
                shreg   <= {rx_sync, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end

            if (state == R_PARITY && bit_tick && !parity_ok)
                err <= 1'b1;

            if (state == R_STOP && bit_tick) begin
                if (rx_sync) begin
                    rx_byte    <= shreg;
                    byte_valid <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// -----------------------------------------------------------------------------
// uart_mem_loader
// Receives "cmd, N, byte0..byteN-1" over UART and writes each data byte to a
// word of data memory. 'S' targets the string region at STR_BASE, 'P' the
// pattern region at PAT_BASE. Byte i goes to base + 4*i as {24'b0, byte}.
// Build option: define UART_RX_PARITY_EN for 8E1 framing (default 8N1).
//
// Ports:
//   System_clk in   sole clock, rising edge
//   BTNU       in   synchronous active-high reset
//   uart_rx    in   serial line, idle high
//   mem_we     out  1-cycle write strobe
//   mem_addr   out  word-aligned byte address of the write
//   mem_wdata  out  {24'b0, received byte}
//   str_len    out  byte count of the last completed string load
//   pat_len    out  byte count of the last completed pattern load
//   busy       out  high from accepted command byte until completion
//   load_done  out  1-cycle pulse on load completion
//   frame_err  out  sticky framing/parity error, cleared only by BTNU
// -----------------------------------------------------------------------------
module uart_mem_loader #(
    parameter int          CLK_FREQ_HZ = 100_000_000,
    parameter int          BAUD        = 9600,
    parameter logic [31:0] STR_BASE    = 32'h0000_0000,
    parameter logic [31:0] PAT_BASE    = 32'h0000_0400
) (
    input  logic        System_clk,
    input  logic        BTNU,
    input  logic        uart_rx,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  str_len,
    output logic [7:0]  pat_len,
    output logic        busy,
    output logic        load_done,
    output logic        frame_err
);
    import uart_pkg::*;

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

    load_state_t state, state_next;
    logic [7:0]  rx_byte;
    logic        rx_valid, rx_err;
    logic        sel_pat;
    logic [7:0]  len_n, remaining, index;
    logic [31:0] base_addr;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (System_clk),
        .rst        (BTNU),
        .rx         (uart_rx),
        .rx_byte    (rx_byte),
        .byte_valid (rx_valid),
        .err        (rx_err)
    );

    assign base_addr = sel_pat ? PAT_BASE : STR_BASE;

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        load_done  = 1'b0;
        case (state)
            L_IDLE: if (rx_valid && (rx_byte == CMD_STR || rx_byte == CMD_PAT))
                        state_next = L_LEN;
            L_LEN: begin
                busy = 1'b1;
                if (rx_valid) state_next = (rx_byte == 8'd0) ? L_DONE : L_DATA;
            end
            L_DATA: begin
                busy = 1'b1;
                if (rx_valid && remaining == 8'd1) state_next = L_DONE;
            end
            L_DONE: begin
                load_done  = 1'b1;
                state_next = L_IDLE;
            end
            default: state_next = L_IDLE;
        endcase
        // A bad frame abandons whatever load is in progress.
        if (rx_err) state_next = L_IDLE;
    end

    always_ff @(posedge System_clk) begin
        if (BTNU) state <= L_IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge System_clk) begin
        if (BTNU) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            str_len   <= '0;
            pat_len   <= '0;
            frame_err <= 1'b0;
            sel_pat   <= 1'b0;
            len_n     <= '0;
            remaining <= '0;
            index     <= '0;
        end else begin
            mem_we <= 1'b0;
            if (rx_err) frame_err <= 1'b1;

            case (state)
                L_IDLE: if (rx_valid) sel_pat <= (rx_byte == CMD_PAT);
                L_LEN: if (rx_valid) begin
                    len_n     <= rx_byte;
                    remaining <= rx_byte;
                    index     <= '0;
                end
                L_DATA: if (rx_valid) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= base_addr + {22'd0, index, 2'b00};
                    mem_wdata <= {24'd0, rx_byte};
                    remaining <= remaining - 8'd1;
                    // Hold the index on the last byte so it tops out at 254.
                    if (remaining != 8'd1) index <= index + 8'd1;
                end
                L_DONE: begin
                    if (sel_pat) pat_len <= len_n;
                    else         str_len <= len_n;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_mem_loader
// Self-checking bench for uart_mem_loader at 10 clocks per bit. Directed
// packets come from a table; random packets are checked against a packet-level
// model (expected write i of a load is base + 4*i with the i-th data byte).
// -----------------------------------------------------------------------------
module tb_uart_mem_loader;
    import uart_pkg::*;

    localparam int          CLK_FREQ_HZ = 1_000_000;
    localparam int          BAUD        = 100_000;
    localparam int          CPB         = CLK_FREQ_HZ / BAUD;
    localparam logic [31:0] STR_BASE    = 32'h0000_0000;
    localparam logic [31:0] PAT_BASE    = 32'h0000_0400;

    logic        System_clk = 1'b0;
    logic        BTNU       = 1'b1;
    logic        uart_rx    = 1'b1;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [7:0]  str_len, pat_len;
    logic        busy, load_done, frame_err;

    always #5 System_clk = ~System_clk;

    uart_mem_loader #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD        (BAUD),
        .STR_BASE    (STR_BASE),
        .PAT_BASE    (PAT_BASE)
    ) dut (
        .System_clk (System_clk),
        .BTNU       (BTNU),
        .uart_rx    (uart_rx),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .str_len    (str_len),
        .pat_len    (pat_len),
        .busy       (busy),
        .load_done  (load_done),
        .frame_err  (frame_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Write/pulse monitor, sampled on the falling edge.
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          done_cnt = 0;

    always @(negedge System_clk) begin
        if (mem_we === 1'b1) begin
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_wdata);
        end
        if (load_done === 1'b1) done_cnt++;
    end

    // Reference state.
    logic [7:0] str_len_m = 8'd0;
    logic [7:0] pat_len_m = 8'd0;
    int         done_m    = 0;

    task automatic wait_clks(input int n);
        repeat (n) @(posedge System_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        uart_rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_clks(CPB);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = ^b;
        wait_clks(CPB);
`endif
        uart_rx = stop_val;
        wait_clks(CPB);
        uart_rx = 1'b1;
        wait_clks(4);
    endtask

    task automatic send_packet(input logic [7:0] cmd, input int n, input logic [63:0] d);
        send_byte(cmd, 1'b1);
        check("busy_after_cmd", {31'd0, busy}, 32'd1);
        send_byte(n[7:0], 1'b1);
        for (int i = 0; i < n; i++) send_byte(d[8*i +: 8], 1'b1);
        wait_clks(20);
        check("busy_after_load", {31'd0, busy}, 32'd0);
    endtask

    // Compare captured writes with the expected n writes of one load.
    task automatic expect_writes(input string name, input logic [31:0] base, input int n, input logic [63:0] d);
        check({name, "_wcount"}, 32'(obs_addr.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (obs_addr.size() > 0) begin
                check({name, "_addr"}, obs_addr.pop_front(), base + 32'(4 * i));
                check({name, "_data"}, obs_data.pop_front(), {24'd0, d[8*i +: 8]});
            end
        end
        obs_addr.delete();
        obs_data.delete();
    endtask

    typedef struct {
        bit          has_pre;
        logic [7:0]  pre;
        logic [7:0]  cmd;
        int          n;
        logic [63:0] d;
        logic [7:0]  exp_str;
        logic [7:0]  exp_pat;
    } vec_t;

    vec_t vecs[3];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{has_pre: 1'b0, pre: 8'h00, cmd: CMD_STR, n: 4, d: 64'h7869_6E75, exp_str: 8'd4, exp_pat: 8'd0};
        vecs[1] = '{has_pre: 1'b0, pre: 8'h00, cmd: CMD_PAT, n: 0, d: 64'h0,         exp_str: 8'd4, exp_pat: 8'd0};
        vecs[2] = '{has_pre: 1'b1, pre: 8'h58, cmd: CMD_PAT, n: 1, d: 64'h41,        exp_str: 8'd4, exp_pat: 8'd1};

        // Reset state.
        wait_clks(3);
        check("rst_mem_we",    {31'd0, mem_we},    32'd0);
        check("rst_mem_addr",  mem_addr,           32'd0);
        check("rst_mem_wdata", mem_wdata,          32'd0);
        check("rst_str_len",   {24'd0, str_len},   32'd0);
        check("rst_pat_len",   {24'd0, pat_len},   32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        BTNU = 1'b0;
        wait_clks(5);

        // Directed packets.
        for (int v = 0; v < 3; v++) begin
            if (vecs[v].has_pre) begin
                send_byte(vecs[v].pre, 1'b1);
                wait_clks(20);
                check("ignored_cmd_busy", {31'd0, busy}, 32'd0);
            end
            send_packet(vecs[v].cmd, vecs[v].n, vecs[v].d);
            done_m++;
            expect_writes("vec", (vecs[v].cmd == CMD_PAT) ? PAT_BASE : STR_BASE, vecs[v].n, vecs[v].d);
            check("vec_str_len", {24'd0, str_len}, {24'd0, vecs[v].exp_str});
            check("vec_pat_len", {24'd0, pat_len}, {24'd0, vecs[v].exp_pat});
            check("vec_done_cnt", 32'(done_cnt), 32'(done_m));
            str_len_m = vecs[v].exp_str;
            pat_len_m = vecs[v].exp_pat;
        end

        // Short low glitch on an idle line: no byte, no error.
        uart_rx = 1'b0;
        wait_clks(3);
        uart_rx = 1'b1;
        wait_clks(40);
        check("glitch_writes",    32'(obs_addr.size()), 32'd0);
        check("glitch_frame_err", {31'd0, frame_err},   32'd0);
        check("glitch_busy",      {31'd0, busy},        32'd0);
        check("glitch_done_cnt",  32'(done_cnt),        32'(done_m));

        // Randomized packets against the model.
        for (int r = 0; r < 6; r++) begin
            logic [7:0]  cmd;
            logic [7:0]  junk;
            int          n;
            logic [63:0] d;
            cmd = ($urandom_range(0, 1) == 1) ? CMD_PAT : CMD_STR;
            n   = int'($urandom_range(0, 6));
            d   = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == CMD_STR || junk == CMD_PAT) junk = 8'h00;
                send_byte(junk, 1'b1);
            end
            send_packet(cmd, n, d);
            if (cmd == CMD_PAT) pat_len_m = 8'(n);
            else                str_len_m = 8'(n);
            done_m++;
            expect_writes("rnd", (cmd == CMD_PAT) ? PAT_BASE : STR_BASE, n, d);
            check("rnd_str_len",  {24'd0, str_len}, {24'd0, str_len_m});
            check("rnd_pat_len",  {24'd0, pat_len}, {24'd0, pat_len_m});
            check("rnd_done_cnt", 32'(done_cnt),    32'(done_m));
        end

        // Bad stop bit on the second data byte of a 3-byte string load.
        send_byte(CMD_STR, 1'b1);
        send_byte(8'd3, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b0);
        wait_clks(20);
        check("ferr_flag", {31'd0, frame_err}, 32'd1);
        check("ferr_busy", {31'd0, busy},      32'd0);
        expect_writes("ferr", STR_BASE, 1, 64'hA5);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        wait_clks(20);
        expect_writes("ferr_after", STR_BASE, 0, 64'h0);
        check("ferr_sticky",   {31'd0, frame_err}, 32'd1);
        check("ferr_str_len",  {24'd0, str_len},   {24'd0, str_len_m});
        check("ferr_pat_len",  {24'd0, pat_len},   {24'd0, pat_len_m});
        check("ferr_done_cnt", 32'(done_cnt),      32'(done_m));

        // Reset after 2 of 5 data bytes.
        send_byte(CMD_STR, 1'b1);
        send_byte(8'd5, 1'b1);
        send_byte(8'h61, 1'b1);
        send_byte(8'h62, 1'b1);
        expect_writes("mid", STR_BASE, 2, 64'h6261);
        BTNU = 1'b1;
        wait_clks(1);
        check("mid_rst_mem_we",    {31'd0, mem_we},    32'd0);
        check("mid_rst_mem_addr",  mem_addr,           32'd0);
        check("mid_rst_mem_wdata", mem_wdata,          32'd0);
        check("mid_rst_str_len",   {24'd0, str_len},   32'd0);
        check("mid_rst_pat_len",   {24'd0, pat_len},   32'd0);
        check("mid_rst_busy",      {31'd0, busy},      32'd0);
        check("mid_rst_load_done", {31'd0, load_done}, 32'd0);
        check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
        BTNU = 1'b0;
        wait_clks(2);
        done_cnt = 0;
        send_byte(8'h31, 1'b1);
        send_byte(8'h32, 1'b1);
        send_byte(8'h33, 1'b1);
        wait_clks(20);
        expect_writes("post_rst", STR_BASE, 0, 64'h0);
        check("post_rst_str_len",  {24'd0, str_len}, 32'd0);
        check("post_rst_busy",     {31'd0, busy},    32'd0);
        check("post_rst_done_cnt", 32'(done_cnt),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
